vec_wb_sequencer: RTL and testbench



---
 rtl/vec_wb_sequencer.sv | 111 +++++++++++
 tb/tb_vec_wb_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vec_wb_sequencer.sv
// Single-port vector register-file write sequencer: arbitrates ALU and load
// results, then streams each accepted vector as BEATS narrow beats.
module vec_wb_sequencer #(
    parameter int LANES = 8,
    parameter int BEAT  = 2,
    parameter int DW    = 8,
    parameter int RAW   = 3,
    localparam int BEATS = LANES / BEAT,
    localparam int BCW   = $clog2(BEATS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_req,
    input  logic [RAW-1:0]        alu_rd,
    input  logic [LANES*DW-1:0]   alu_data,
    output logic                  alu_ack,
    input  logic                  mem_req,
    input  logic [RAW-1:0]        mem_rd,
    input  logic [LANES*DW-1:0]   mem_data,
    output logic                  mem_ack,
    output logic                  rf_we,
    output logic [RAW-1:0]        rf_rd,
    output logic [BCW-1:0]        rf_beat,
    output logic [BEAT*DW-1:0]    rf_wdata,
    output logic                  stall
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_e;

    localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

    state_e              state_q, state_d;
    logic [BCW-1:0]      beat_q, beat_d;
    logic [RAW-1:0]      rd_q, rd_d;
    logic [LANES*DW-1:0] data_q, data_d;
    logic                ptr_q, ptr_d;   // 0: ALU has priority, 1: MEM has priority
    logic                accept;
    logic                grant_alu;
    logic                grant_mem;

    // Handshake: a requester holds req/rd/data stable until its ack; ack is
    // combinational and the transfer completes on the clock edge where ack=1.
    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        rd_d      = rd_q;
        data_d    = data_q;
        ptr_d     = ptr_q;
        alu_ack   = 1'b0;
        mem_ack   = 1'b0;
        accept    = (state_q == IDLE) || (beat_q == LAST_BEAT);
        grant_alu = alu_req && (!mem_req || !ptr_q);
        grant_mem = mem_req && (!alu_req || ptr_q);

        if (!rst && accept) begin
            alu_ack = grant_alu;
            mem_ack = grant_mem;
        end

        if (state_q == WRITE) begin
            if (beat_q == LAST_BEAT) begin
                state_d = IDLE;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + 1'b1;
            end
        end

        // A new acceptance on the last beat overrides the return to IDLE,
        // giving back-to-back sequences with no bubble.
        if (alu_ack) begin
            rd_d    = alu_rd;
            data_d  = alu_data;
            state_d = WRITE;
            beat_d  = '0;
            ptr_d   = 1'b1;
        end else if (mem_ack) begin
            rd_d    = mem_rd;
            data_d  = mem_data;
            state_d = WRITE;
            beat_d  = '0;
            ptr_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            ptr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            ptr_q   <= ptr_d;
        end
    end

    assign rf_we    = (state_q == WRITE);
    assign stall    = (state_q == WRITE);
    assign rf_rd    = rf_we ? rd_q : '0;
    assign rf_beat  = rf_we ? beat_q : '0;
    assign rf_wdata = rf_we ? data_q[int'(beat_q)*BEAT*DW +: BEAT*DW] : '0;

endmodule

// File: tb/tb_vec_wb_sequencer.sv
// Directed bench for vec_wb_sequencer: reset, single write, arbitration,
// round-robin, late request and mid-sequence reset.
module tb_vec_wb_sequencer;

    localparam int LANES = 8;
    localparam int BEAT  = 2;
    localparam int DW    = 8;
    localparam int RAW   = 3;
    localparam int BEATS = LANES / BEAT;
    localparam int BCW   = $clog2(BEATS);

    logic                clk = 1'b0;
    logic                rst;
    logic                alu_req, mem_req;
    logic [RAW-1:0]      alu_rd, mem_rd;
    logic [LANES*DW-1:0] alu_data, mem_data;
    logic                alu_ack, mem_ack;
    logic                rf_we;
    logic [RAW-1:0]      rf_rd;
    logic [BCW-1:0]      rf_beat;
    logic [BEAT*DW-1:0]  rf_wdata;
    logic                stall;

    int n_vec = 0;
    int n_err = 0;
    logic [BEAT*DW-1:0] exp_q[$];

    vec_wb_sequencer #(.LANES(LANES), .BEAT(BEAT), .DW(DW), .RAW(RAW)) dut (
        .clk(clk), .rst(rst),
        .alu_req(alu_req), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ack(alu_ack),
        .mem_req(mem_req), .mem_rd(mem_rd), .mem_data(mem_data), .mem_ack(mem_ack),
        .rf_we(rf_we), .rf_rd(rf_rd), .rf_beat(rf_beat), .rf_wdata(rf_wdata),
        .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the edge, outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [LANES*DW-1:0] make_vec(input logic [7:0] base);
        logic [LANES*DW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DW +: DW] = base + 8'(i);
        return v;
    endfunction

    function automatic logic [BEAT*DW-1:0] beat_word(input logic [7:0] base, input int b);
        return {base + 8'(2*b + 1), base + 8'(2*b)};
    endfunction

    task automatic chk_idle(input string tag);
        check({tag, "_we"},    64'(rf_we),    64'd0);
        check({tag, "_rd"},    64'(rf_rd),    64'd0);
        check({tag, "_beat"},  64'(rf_beat),  64'd0);
        check({tag, "_wdata"}, 64'(rf_wdata), 64'd0);
        check({tag, "_stall"}, 64'(stall),    64'd0);
    endtask

    task automatic chk_beat(input string tag, input logic [RAW-1:0] rd, input int b,
                            input logic [BEAT*DW-1:0] w);
        check({tag, "_we"},    64'(rf_we),    64'd1);
        check({tag, "_rd"},    64'(rf_rd),    64'(rd));
        check({tag, "_beat"},  64'(rf_beat),  64'(b));
        check({tag, "_wdata"}, 64'(rf_wdata), 64'(w));
        check({tag, "_stall"}, 64'(stall),    64'd1);
    endtask

    task automatic chk_acks(input string tag, input logic a, input logic m);
        check({tag, "_alu_ack"}, 64'(alu_ack), 64'(a));
        check({tag, "_mem_ack"}, 64'(mem_ack), 64'(m));
    endtask

    initial begin
        logic [7:0] alu_base_seq [4];
        logic [RAW-1:0] rd_seq [4];
        int waited;

        rst = 1'b1;
        alu_req = 1'b0; alu_rd = '0; alu_data = '0;
        mem_req = 1'b0; mem_rd = '0; mem_data = '0;

        // Reset then idle
        tick(); settle();
        chk_idle("rst_hold");
        tick();
        rst = 1'b0;
        settle();
        chk_idle("rst_idle");
        chk_acks("rst_idle", 1'b0, 1'b0);

        // Single ALU write, literal expected beats
        alu_req = 1'b1; alu_rd = 3'd5; alu_data = make_vec(8'h10);
        settle();
        chk_acks("single_req", 1'b1, 1'b0);
        check("single_req_we", 64'(rf_we), 64'd0);
        tick(); alu_req = 1'b0; settle();
        chk_beat("single_b0", 3'd5, 0, 16'h1110);
        chk_acks("single_b0", 1'b0, 1'b0);
        tick(); settle(); chk_beat("single_b1", 3'd5, 1, 16'h1312);
        tick(); settle(); chk_beat("single_b2", 3'd5, 2, 16'h1514);
        tick(); settle(); chk_beat("single_b3", 3'd5, 3, 16'h1716);
        tick(); settle(); chk_idle("single_done");

        // Simultaneous requests right after reset: ALU first, MEM with no gap
        rst = 1'b1; tick(); rst = 1'b0;
        alu_req = 1'b1; alu_rd = 3'd1; alu_data = make_vec(8'h20);
        mem_req = 1'b1; mem_rd = 3'd2; mem_data = make_vec(8'h40);
        settle();
        chk_acks("simul_req", 1'b1, 1'b0);
        tick(); alu_req = 1'b0; settle();
        for (int b = 0; b < BEATS; b++) begin
            chk_beat($sformatf("simul_alu_b%0d", b), 3'd1, b, beat_word(8'h20, b));
            chk_acks($sformatf("simul_alu_b%0d", b), 1'b0, (b == BEATS-1));
            tick();
            if (b == BEATS-1) mem_req = 1'b0;
            settle();
        end
        for (int b = 0; b < BEATS; b++) begin
            chk_beat($sformatf("simul_mem_b%0d", b), 3'd2, b, beat_word(8'h40, b));
            tick(); settle();
        end
        chk_idle("simul_done");

        // Round-robin with both held high: grants ALU, MEM, ALU, MEM
        alu_base_seq = '{8'h50, 8'h60, 8'h70, 8'h80};
        rd_seq       = '{3'd3, 3'd4, 3'd6, 3'd7};
        alu_req = 1'b1; alu_rd = rd_seq[0]; alu_data = make_vec(alu_base_seq[0]);
        mem_req = 1'b1; mem_rd = rd_seq[1]; mem_data = make_vec(alu_base_seq[1]);
        settle();
        for (int g = 0; g < 4; g++) begin
            chk_acks($sformatf("rr_grant%0d", g), (g % 2 == 0), (g % 2 == 1));
            for (int b = 0; b < BEATS; b++) exp_q.push_back(beat_word(alu_base_seq[g], b));
            tick();
            if (g == 0) begin alu_rd = rd_seq[2]; alu_data = make_vec(alu_base_seq[2]); end
            if (g == 1) begin mem_rd = rd_seq[3]; mem_data = make_vec(alu_base_seq[3]); end
            if (g == 2) alu_req = 1'b0;
            if (g == 3) mem_req = 1'b0;
            settle();
            for (int b = 0; b < BEATS; b++) begin
                chk_beat($sformatf("rr_g%0d_b%0d", g, b), rd_seq[g], b, exp_q.pop_front());
                if (b < BEATS-1) begin
                    chk_acks($sformatf("rr_g%0d_b%0d", g, b), 1'b0, 1'b0);
                    tick(); settle();
                end
            end
        end
        tick(); settle();
        chk_idle("rr_done");

        // Late MEM request during an ALU sequence
        alu_req = 1'b1; alu_rd = 3'd2; alu_data = make_vec(8'h90);
        settle();
        chk_acks("late_req", 1'b1, 1'b0);
        tick(); alu_req = 1'b0; settle();
        chk_beat("late_b0", 3'd2, 0, 16'h9190);
        tick(); settle();
        chk_beat("late_b1", 3'd2, 1, 16'h9392);
        tick();
        mem_req = 1'b1; mem_rd = 3'd5; mem_data = make_vec(8'hA0);
        settle();
        chk_beat("late_b2", 3'd2, 2, 16'h9594);
        chk_acks("late_b2", 1'b0, 1'b0);
        tick(); settle();
        chk_beat("late_b3", 3'd2, 3, 16'h9796);
        chk_acks("late_b3", 1'b0, 1'b1);
        tick(); mem_req = 1'b0; settle();
        chk_beat("late_mem_b0", 3'd5, 0, 16'hA1A0);
        for (int b = 1; b < BEATS; b++) begin tick(); settle(); end
        chk_beat("late_mem_b3", 3'd5, 3, 16'hA7A6);
        tick(); settle();
        chk_idle("late_done");

        // Reset during beat 1 of a MEM write
        mem_req = 1'b1; mem_rd = 3'd1; mem_data = make_vec(8'hB0);
        settle();
        chk_acks("rstmid_mem_req", 1'b0, 1'b1);
        tick(); mem_req = 1'b0; settle();
        chk_beat("rstmid_b0", 3'd1, 0, 16'hB1B0);
        tick(); rst = 1'b1; alu_req = 1'b1; alu_rd = 3'd6; alu_data = make_vec(8'hE0);
        settle();
        chk_beat("rstmid_b1", 3'd1, 1, 16'hB3B2);
        chk_acks("rstmid_in_rst", 1'b0, 1'b0);
        tick(); rst = 1'b0; alu_req = 1'b0; settle();
        chk_idle("rstmid_after");

        // Reset during an ALU write: pointer must fall back to ALU
        alu_req = 1'b1; alu_rd = 3'd4; alu_data = make_vec(8'hF0);
        settle();
        chk_acks("rstalu_req", 1'b1, 1'b0);
        tick(); alu_req = 1'b0; rst = 1'b1; settle();
        tick(); rst = 1'b0;
        alu_req = 1'b1; alu_rd = 3'd7; alu_data = make_vec(8'hC0);
        mem_req = 1'b1; mem_rd = 3'd3; mem_data = make_vec(8'hD0);
        settle();
        chk_idle("rstalu_after");
        chk_acks("rstalu_both", 1'b1, 1'b0);
        tick(); alu_req = 1'b0; settle();
        chk_beat("rstalu_b0", 3'd7, 0, 16'hC1C0);
        waited = 0;
        while (!mem_ack && waited < 10) begin tick(); settle(); waited++; end
        check("rstalu_mem_ack_wait", 64'(waited), 64'd3);
        tick(); mem_req = 1'b0; settle();
        chk_beat("rstalu_mem_b0", 3'd3, 0, 16'hD1D0);
        waited = 0;
        while (stall && waited < 20) begin tick(); settle(); waited++; end
        check("drain_timeout", 64'(stall), 64'd0);
        chk_idle("final_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
